// File: rtl/i2c_slave_model.sv
`default_nettype none
// ====================================================================
// i2c_slave_model: oversampled I2C slave with pointer-addressed byte register file
// Rev 1.0
// ====================================================================
module i2c_slave_model #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h67,
  parameter int         MEM_DEPTH   = 16,
  parameter int         PTR_WIDTH   = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         DATA_HOLD   = 2
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 i2c_core_rst_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  output logic                 i2c_sda_en_o,
  output logic                 addr_match_o,
  output logic                 start_det_o,
  output logic                 stop_det_o,
  output logic                 wr_en_o,
  output logic [PTR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]           wr_data_o,
  input  logic [PTR_WIDTH-1:0] dbg_addr_i,
  output logic [7:0]           dbg_data_o
);

  localparam int HOLD_W = $clog2(DATA_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_PTR      = 4'd3,
    S_DATA_ACK = 4'd4,
    S_WDATA    = 4'd5,
    S_RDATA    = 4'd6,
    S_RMACK    = 4'd7,
    S_WAIT     = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [7:0]             r_mem [MEM_DEPTH];

  state_t                 r_state, w_state_n;
  logic                   r_sda_en, w_sda_en_n;
  logic                   r_match, w_match_n;
  logic [3:0]             r_cnt, w_cnt_n;
  logic [7:0]             r_shift, w_shift_n;
  logic [PTR_WIDTH-1:0]   r_ptr, w_ptr_n;
  logic                   r_ack_drv, w_ack_drv_n;
  logic                   r_byte_done, w_byte_done_n;
  logic                   r_start_det, r_stop_det, r_wr_en;
  logic [PTR_WIDTH-1:0]   r_wr_addr;
  logic [7:0]             r_wr_data;

  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall;
  logic                   w_start, w_stop, w_drive, w_commit;
  logic [PTR_WIDTH-1:0]   w_ptr_inc;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // START/STOP need SCL high before and after the SDA edge, so a same-cycle SCL change never qualifies
  assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;
  assign w_drive    = (r_hold_cnt == HOLD_W'(1));
  assign w_commit   = (r_state == S_WDATA) && r_byte_done;
  assign w_ptr_inc  = r_ptr + PTR_WIDTH'(1);

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      if (w_scl_fall)
        r_hold_cnt <= HOLD_W'(DATA_HOLD);
      else if (r_hold_cnt != '0)
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_sda_en_n    = r_sda_en;
    w_match_n     = r_match;
    w_cnt_n       = r_cnt;
    w_shift_n     = r_shift;
    w_ptr_n       = w_commit ? w_ptr_inc : r_ptr;
    w_ack_drv_n   = r_ack_drv;
    w_byte_done_n = 1'b0;
    if (w_stop) begin
      w_state_n   = S_IDLE;
      w_sda_en_n  = 1'b0;
      w_match_n   = 1'b0;
      w_cnt_n     = '0;
      w_ack_drv_n = 1'b0;
    end else if (w_start) begin
      w_state_n   = S_ADDR;
      w_sda_en_n  = 1'b0;
      w_match_n   = 1'b0;
      w_cnt_n     = '0;
      w_ack_drv_n = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (r_byte_done) begin
            w_cnt_n = '0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                w_state_n = S_ADDR_ACK;
                w_match_n = 1'b1;
              end else begin
                w_state_n = S_WAIT;
              end
            end else if (r_state == S_PTR) begin
              if (int'({24'd0, r_shift}) < MEM_DEPTH) begin
                w_ptr_n   = r_shift[PTR_WIDTH-1:0];
                w_state_n = S_DATA_ACK;
              end else begin
                w_match_n = 1'b0;
                w_state_n = S_WAIT;
              end
            end else begin
              w_state_n = S_DATA_ACK;
            end
          end else if (w_scl_rise && r_cnt < 4'd8) begin
            w_shift_n     = {r_shift[6:0], w_sda};
            w_cnt_n       = r_cnt + 4'd1;
            w_byte_done_n = (r_cnt == 4'd7);
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First hold point after the 8th bit pulls ACK; the next one ends the ACK slot
          if (w_drive) begin
            if (!r_ack_drv) begin
              w_sda_en_n  = 1'b1;
              w_ack_drv_n = 1'b1;
            end else begin
              w_ack_drv_n = 1'b0;
              w_sda_en_n  = 1'b0;
              if (r_state == S_DATA_ACK) begin
                w_state_n = S_WDATA;
              end else if (r_shift[0]) begin
                w_state_n  = S_RDATA;
                w_sda_en_n = ~r_mem[r_ptr][7];
                w_shift_n  = {r_mem[r_ptr][6:0], 1'b0};
                w_cnt_n    = 4'd1;
              end else begin
                w_state_n = S_PTR;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_drive) begin
            if (r_cnt == 4'd8) begin
              w_sda_en_n = 1'b0;
              w_cnt_n    = '0;
              w_state_n  = S_RMACK;
            end else begin
              w_sda_en_n = ~r_shift[7];
              w_shift_n  = {r_shift[6:0], 1'b0};
              w_cnt_n    = r_cnt + 4'd1;
            end
          end
        end
        S_RMACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_n   = w_ptr_inc;
              w_shift_n = r_mem[w_ptr_inc];
              w_cnt_n   = '0;
              w_state_n = S_RDATA;
            end else begin
              w_sda_en_n = 1'b0;
              w_match_n  = 1'b0;
              w_state_n  = S_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      r_state     <= S_IDLE;
      r_sda_en    <= 1'b0;
      r_match     <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_ack_drv   <= 1'b0;
      r_byte_done <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_sda_en    <= w_sda_en_n;
      r_match     <= w_match_n;
      r_cnt       <= w_cnt_n;
      r_shift     <= w_shift_n;
      r_ptr       <= w_ptr_n;
      r_ack_drv   <= w_ack_drv_n;
      r_byte_done <= w_byte_done_n;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
      r_wr_en     <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
      end
    end
  end

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_ptr] <= r_shift;
    end
  end

  assign i2c_sda_o    = 1'b0;
  assign i2c_sda_en_o = r_sda_en;
  assign addr_match_o = r_match;
  assign start_det_o  = r_start_det;
  assign stop_det_o   = r_stop_det;
  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign dbg_data_o   = r_mem[dbg_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_model.sv
`default_nettype none
// ====================================================================
// tb_i2c_slave_model: directed I2C master against i2c_slave_model over a wired-AND SDA
// Rev 1.0
// ====================================================================
module tb_i2c_slave_model;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       w_sda_bus;
  logic       sda_o, sda_en, addr_match, start_det, stop_det, wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] dbg_addr = 4'd0;
  logic [7:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr = 0, n_start = 0, n_stop = 0, n_en_cyc = 0, n_match_cyc = 0;
  logic [3:0] q_addr [$];
  logic [7:0] q_data [$];

  always #5 clk = ~clk;

  assign w_sda_bus = m_sda & ~(sda_en & ~sda_o);

  i2c_slave_model dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_i (rst),
    .i2c_scl_i      (m_scl),
    .i2c_sda_i      (w_sda_bus),
    .i2c_sda_o      (sda_o),
    .i2c_sda_en_o   (sda_en),
    .addr_match_o   (addr_match),
    .start_det_o    (start_det),
    .stop_det_o     (stop_det),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .dbg_addr_i     (dbg_addr),
    .dbg_data_o     (dbg_data)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr <= n_wr + 1;
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
    if (start_det)  n_start     <= n_start + 1;
    if (stop_det)   n_stop      <= n_stop + 1;
    if (sda_en)     n_en_cyc    <= n_en_cyc + 1;
    if (addr_match) n_match_cyc <= n_match_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic bit_w(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = w_sda_bus; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask

  task automatic byte_r(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(nack);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s_wr, s_start, s_stop, s_en, s_match;

    // Reset state
    #20;
    chk("rst_sda_en", {31'd0, sda_en}, 32'd0);
    mem_chk("rst_dbg_mem7", 4'd7, 8'h00);
    #30;
    rst = 1'b0;
    #40;
    chk("rst_sda_o", {31'd0, sda_o}, 32'd0);
    chk("rst_match", {31'd0, addr_match}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_pulses", {30'd0, start_det, stop_det}, 32'd0);

    // Write burst: ptr 3, A5, 5A
    s_wr = n_wr; s_start = n_start; s_stop = n_stop;
    i2c_start();
    byte_w(8'hCE, ack); chk("wb_addr_ack", {31'd0, ack}, 32'd0);
    chk("wb_match", {31'd0, addr_match}, 32'd1);
    byte_w(8'h03, ack); chk("wb_ptr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'hA5, ack); chk("wb_d0_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h5A, ack); chk("wb_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("wb_wr_count", n_wr - s_wr, 32'd2);
    chk("wb_wr0", {20'd0, q_addr[0], q_data[0]}, 32'h3A5);
    chk("wb_wr1", {20'd0, q_addr[1], q_data[1]}, 32'h45A);
    mem_chk("wb_mem3", 4'd3, 8'hA5);
    mem_chk("wb_mem4", 4'd4, 8'h5A);
    chk("wb_stop_pulses", n_stop - s_stop, 32'd1);
    chk("wb_start_pulses", n_start - s_start, 32'd1);
    chk("wb_match_after_stop", {31'd0, addr_match}, 32'd0);

    // Combined read via repeated START
    s_start = n_start;
    i2c_start();
    byte_w(8'hCE, ack); chk("cr_addr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h03, ack); chk("cr_ptr_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    byte_w(8'hCF, ack); chk("cr_raddr_ack", {31'd0, ack}, 32'd0);
    byte_r(1'b0, rd); chk("cr_rd0", {24'd0, rd}, 32'hA5);
    byte_r(1'b1, rd); chk("cr_rd1", {24'd0, rd}, 32'h5A);
    chk("cr_sda_released", {31'd0, sda_en}, 32'd0);
    chk("cr_match_cleared", {31'd0, addr_match}, 32'd0);
    i2c_stop();
    chk("cr_start_pulses", n_start - s_start, 32'd2);

    // Wrong address: slave stays silent
    s_wr = n_wr; s_en = n_en_cyc; s_match = n_match_cyc;
    i2c_start();
    byte_w(8'hA0, ack); chk("wa_addr_nack", {31'd0, ack}, 32'd1);
    byte_w(8'h55, ack); chk("wa_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("wa_en_cycles", n_en_cyc - s_en, 32'd0);
    chk("wa_wr_count", n_wr - s_wr, 32'd0);
    chk("wa_match_cycles", n_match_cyc - s_match, 32'd0);

    // Pointer wrap, then out-of-range pointer
    s_wr = n_wr;
    i2c_start();
    byte_w(8'hCE, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h0F, ack); chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h11, ack); chk("wr_d0_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h22, ack); chk("wr_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("wr_wr_count", n_wr - s_wr, 32'd2);
    chk("wr_wr2", {20'd0, q_addr[2], q_data[2]}, 32'hF11);
    chk("wr_wr3", {20'd0, q_addr[3], q_data[3]}, 32'h022);
    mem_chk("wr_mem15", 4'd15, 8'h11);
    mem_chk("wr_mem0", 4'd0, 8'h22);
    s_wr = n_wr;
    i2c_start();
    byte_w(8'hCE, ack); chk("or_addr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h10, ack); chk("or_ptr_nack", {31'd0, ack}, 32'd1);
    chk("or_match_cleared", {31'd0, addr_match}, 32'd0);
    byte_w(8'h77, ack); chk("or_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("or_wr_count", n_wr - s_wr, 32'd0);
    mem_chk("or_mem0", 4'd0, 8'h22);

    // Aborted byte: STOP after 4 data bits
    s_wr = n_wr;
    i2c_start();
    byte_w(8'hCE, ack); chk("ab_addr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h05, ack); chk("ab_ptr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) bit_w(1'b1);
    i2c_stop();
    chk("ab_wr_count", n_wr - s_wr, 32'd0);
    mem_chk("ab_mem5", 4'd5, 8'h00);

    // Reset mid-read: pointer is 5, mem[5]=00, so bit 7 is driven low
    i2c_start();
    byte_w(8'hCF, ack); chk("rr_addr_ack", {31'd0, ack}, 32'd0);
    chk("rr_sda_driven", {31'd0, sda_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_sda_released", {31'd0, sda_en}, 32'd0);
    mem_chk("rr_mem3", 4'd3, 8'h00);
    mem_chk("rr_mem4", 4'd4, 8'h00);
    mem_chk("rr_mem15", 4'd15, 8'h00);
    mem_chk("rr_mem0", 4'd0, 8'h00);
    #9;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
    rst = 1'b0;
    #Q;
    chk("rr_match_idle", {31'd0, addr_match}, 32'd0);
    s_wr = n_wr; s_start = n_start;
    i2c_start();
    byte_w(8'hCE, ack); chk("rr2_addr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h02, ack); chk("rr2_ptr_ack", {31'd0, ack}, 32'd0);
    byte_w(8'h3C, ack); chk("rr2_d0_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("rr2_wr_count", n_wr - s_wr, 32'd1);
    chk("rr2_wr", {20'd0, q_addr[4], q_data[4]}, 32'h23C);
    mem_chk("rr2_mem2", 4'd2, 8'h3C);
    chk("rr2_start_pulses", n_start - s_start, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_model.md
Name: i2c_slave_model

Overview:
Synthesisable, parametrised I2C slave with a byte-wide register file. It replaces the constant-driven SDA stub in the top-level benches and is the bus counterpart for i2c_top.
- Oversamples SCL/SDA on i2c_core_clk_i.
- Detects START, repeated START and STOP.
- Supports pointer-based multi-byte writes and reads with auto-increment.
- Drives SDA open-drain through an enable, matching i2c_top's sda/en pairing.

Parameters:
SLAVE_ADDR, 7'h67, 7-bit bus address (0x67 + W = 8'b11001110).
MEM_DEPTH, 16, register count; power of two, 2..256.
PTR_WIDTH, 4, log2(MEM_DEPTH).
SYNC_STAGES, 2, synchroniser flops on SCL and SDA; minimum 2.
DATA_HOLD, 2, core cycles from detected SCL fall to SDA change; must be less than the SCL low time in core cycles.

Ports:
i2c_core_clk_i  in  1  core clock; the only clock.
i2c_core_rst_i  in  1  asynchronous, active-high reset.
i2c_scl_i  in  1  SCL line (resolved bus).
i2c_sda_i  in  1  SDA line (resolved bus).
i2c_sda_o  out  1  SDA drive value; always 0 (open-drain).
i2c_sda_en_o  out  1  1 = pull SDA low; 0 = release.
addr_match_o  out  1  high while this slave is addressed (ADDR_ACK up to STOP, repeated START or NACK).
start_det_o  out  1  one-cycle pulse per START or repeated START.
stop_det_o  out  1  one-cycle pulse per STOP.
wr_en_o  out  1  one-cycle pulse when a data byte is committed.
wr_addr_o  out  PTR_WIDTH  register index of the committed byte.
wr_data_o  out  8  committed byte.
dbg_addr_i  in  PTR_WIDTH  bench-side register read index.
dbg_data_o  out  8  mem[dbg_addr_i], combinational.

Behaviour:
- Reset values (asynchronous):
  - i2c_sda_en_o=0, i2c_sda_o=0.
  - All pulse outputs 0, addr_match_o=0, wr_addr_o=0, wr_data_o=0.
  - Every mem entry = 8'h00, pointer=0, state=IDLE.
- Reset asserted mid-transfer releases SDA in the same instant.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, then one edge-detect register.
  - All events below refer to the synchronised signals.
- Events:
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Bits are sampled on SCL rise.
  - SDA output changes DATA_HOLD cycles after an SCL fall.
- Priority: STOP and START override any state.
  - STOP -> IDLE; release SDA; addr_match_o=0.
  - START -> ADDR; bit counter cleared; pointer retained, so repeated-START reads continue from the last pointer.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - Bits [7:1]==SLAVE_ADDR -> ADDR_ACK.
    - Otherwise -> WAIT; SDA never driven.
  - ADDR_ACK: drive SDA low for the 9th SCL period; set addr_match_o.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA, loading mem[pointer] into the shift register.
  - PTR: shift 8 bits.
    - Value < MEM_DEPTH -> pointer=value, ACK -> WDATA.
    - Value >= MEM_DEPTH -> NACK (SDA released), addr_match_o=0 -> WAIT.
  - WDATA: shift 8 bits.
    - One cycle after the 8th sample: wr_en_o pulse, mem[pointer]=byte, wr_addr_o=pointer, wr_data_o=byte.
    - Then pointer = (pointer+1) mod MEM_DEPTH and ACK -> WDATA. Writes are unlimited and wrap.
  - RDATA: for each of 8 bits, release SDA for a 1 and drive low for a 0, MSB first.
    - After the 8th bit, release SDA -> RMACK.
  - RMACK: sample the master's ACK bit on SCL rise.
    - 0 -> pointer++ (wrap), load next byte -> RDATA.
    - 1 -> release SDA, addr_match_o=0 -> WAIT.
  - WAIT: SDA released; only START or STOP leaves this state.
- Simultaneous events: if the internal wr_en_o commit and a STOP land in the same cycle, the commit still happens.
- A byte interrupted before its 8th bit is discarded; mem is unchanged.
- The same-cycle SCL/SDA edge rule is decided in the following order:
  1. A simultaneous SCL and SDA change is not a START or STOP.
  2. SCL-high is judged on the registered (previous) SCL value.
- dbg_data_o is valid in all states, including during reset (reads 0).

Test Plan:
- Write burst: START, 0xCE, ptr 0x03, bytes 0xA5, 0x5A, STOP -> four ACKs; wr_en_o pulses with (3,A5) then (4,5A); dbg mem[3]=A5, mem[4]=5A; stop_det_o pulses once.
- Combined read: write ptr 0x03, repeated START, 0xCF, master ACK then NACK -> slave returns A5 then 5A; SDA released after the NACK; start_det_o pulses twice.
- Wrong address: START, 0xA0, data, STOP -> i2c_sda_en_o stays 0 throughout; no wr_en_o; addr_match_o stays 0.
- Wrap/range: ptr 0x0F, bytes 11, 22 -> mem[15]=11, mem[0]=22. Then ptr 0x10 -> pointer byte NACKed and the next data byte is ignored.
- Reset mid-read: assert i2c_core_rst_i while the slave holds SDA low -> i2c_sda_en_o=0 immediately; all mem = 00; the next transaction starts from IDLE.
- Aborted byte: STOP after 4 data bits of a write -> no wr_en_o; mem unchanged.
